// File: rtl/result_arbiter_pkg.sv
// Shared types for the result arbiter: producer indices and the result payload.
package result_arbiter_pkg;

  localparam int N_RESULT_SRC = 5;

  localparam int ALU  = 0;
  localparam int BU   = 1;
  localparam int FPU  = 2;
  localparam int UART = 3;
  localparam int MEM  = 4;

  typedef struct packed {
    logic [5:0]  commit_id;
    logic [31:0] value;
  } result_t;

endpackage

// File: rtl/result_arbiter_rr_picker.sv
// Round-robin picker: first set bit of req at or above ptr, wrapping modulo N.
module result_arbiter_rr_picker #(
  parameter int N = 5,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          none
);

  int c;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx  = ptr;
    none = 1'b1;
    c    = 0;
    // Walk offsets from farthest to nearest so the nearest requester is the last to win.
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) begin
        idx  = PW'(c);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Round-robin result arbiter with stall lock.
// Define RESULT_ARBITER_OUT_REG_EN for a one-entry registered output; default is combinational.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int  N_REQ = N_RESULT_SRC,
  parameter type T_MSG = result_t
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flash,
  input  logic [N_REQ-1:0] req_en,
  input  T_MSG             req_msg [N_REQ],
  output logic [N_REQ-1:0] req_reject,
  output logic             out_en,
  output T_MSG             out_msg,
  input  logic             out_reject
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] rr_idx;
  logic [PW-1:0] win;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] lk_q;
  logic          locked_q;
  logic          none;
  logic          any;
  logic          lock_hit;
  logic          take;

  result_arbiter_rr_picker #(.N(N_REQ)) u_picker (
    .req  (req_en),
    .ptr  (ptr_q),
    .idx  (rr_idx),
    .none (none)
  );

  assign any      = ~none;
  assign lock_hit = locked_q & req_en[lk_q];
  assign win      = lock_hit ? lk_q : rr_idx;
  assign ptr_next = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);

`ifdef RESULT_ARBITER_OUT_REG_EN
  logic v_q;
  T_MSG d_q;
  logic slot_free;

  assign locked_q  = 1'b0;
  assign lk_q      = '0;
  assign slot_free = ~v_q | ~out_reject;
  assign take      = any & slot_free & ~flash & ~reset;
  assign out_en    = v_q & ~flash & ~reset;
  assign out_msg   = d_q;

  always_ff @(posedge clock) begin
    if (reset)           v_q <= 1'b0;
    else if (flash)      v_q <= 1'b0;
    else if (take)       v_q <= 1'b1;
    else if (!out_reject) v_q <= 1'b0;
  end

  // NOTE: the payload register is qualified by v_q, so it needs no reset.
  always_ff @(posedge clock) begin
    if (take) d_q <= req_msg[win];
  end
`else
  assign take    = any & ~out_reject & ~flash & ~reset;
  assign out_en  = any & ~flash & ~reset;
  assign out_msg = req_msg[win];

  // Hold the stalled winner so out_msg stays stable until it is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      locked_q <= 1'b0;
      lk_q     <= '0;
    end else if (flash || take) begin
      locked_q <= 1'b0;
    end else if (out_en && out_reject) begin
      locked_q <= 1'b1;
      lk_q     <= win;
    end else if (locked_q && any && !req_en[lk_q]) begin
      locked_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    req_reject = '1;
    if (take) req_reject[win] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)     ptr_q <= '0;
    else if (take) ptr_q <= ptr_next;
  end

endmodule
